// File: rtl/fmult_accum_pkg.sv
// Shared types and constants for the fmult_accum_seq block.
// Covers the sequencer states, the SRn field layout and the datapath widths.
package fmult_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SR_W        = 11;
   localparam int SR_S_POS    = 10;
   localparam int SR_EXP_MSB  = 9;
   localparam int SR_EXP_LSB  = 6;
   localparam int SR_MANT_MSB = 5;
   localparam int SR_MANT_LSB = 0;

   localparam int A_W      = 16;
   localparam int MAG_W    = 13;
   localparam int WMAG_W   = 15;
   localparam int ROUND_K  = 48;
   localparam int EXP_BIAS = 26;

   // Number of significant bits in a 13-bit magnitude (0 for zero).
   function automatic logic [3:0] bit_length13(input logic [12:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 13; i++) begin
         if (v[i]) n = 4'(i + 1);
         else      n = n;
      end
      return n;
   endfunction

endpackage

// File: rtl/fmult_accum_seq_fmult.sv
// Combinational G.726-style float multiply of one coefficient An by one SRn operand.
// Produces the signed 16-bit weighted product WAn.
module fmult
   import fmult_accum_pkg::*;
(
   input  logic [15:0] an,
   input  logic [10:0] srn,
   output logic [15:0] wan
);

   logic        an_s;
   logic        sr_s;
   logic [15:0] an_abs;
   logic [12:0] an_mag;
   logic [3:0]  an_exp;
   logic [5:0]  an_mant;
   logic [3:0]  sr_exp;
   logic [5:0]  sr_mant;
   logic [4:0]  wa_exp;
   logic [8:0]  wa_mant;
   logic [17:0] mag_base;
   logic [14:0] wa_mag;

   assign an_s    = an[A_W-1];
   assign sr_s    = srn[SR_S_POS];
   assign sr_exp  = srn[SR_EXP_MSB:SR_EXP_LSB];
   assign sr_mant = srn[SR_MANT_MSB:SR_MANT_LSB];

   // -32768 yields 0x2000 here, which the 13-bit truncation turns into zero.
   assign an_abs  = an_s ? (16'd0 - an) : an;
   assign an_mag  = 13'(an_abs >> 2);
   assign an_exp  = bit_length13(an_mag);
   assign an_mant = (an_mag == 13'd0) ? 6'd32 : 6'({an_mag, 6'd0} >> an_exp);

   assign wa_exp   = {1'b0, sr_exp} + {1'b0, an_exp};
   assign wa_mant  = 9'((({7'd0, sr_mant} * {7'd0, an_mant}) + 13'(ROUND_K)) >> 4);
   assign mag_base = {2'b00, wa_mant, 7'd0};

   // Align the mantissa product to the exponent, keeping only 15 magnitude bits.
   always_comb begin
      wa_mag = 15'd0;
      if (wa_exp > 5'(EXP_BIAS)) begin
         wa_mag = 15'(mag_base << (wa_exp - 5'(EXP_BIAS)));
      end else begin
         wa_mag = 15'(mag_base >> (5'(EXP_BIAS) - wa_exp));
      end
   end

   assign wan = (an_s ^ sr_s) ? (16'd0 - {1'b0, wa_mag}) : {1'b0, wa_mag};

endmodule

// File: rtl/fmult_accum_seq.sv
// Sequential multiply-accumulate over NZ zero taps then NP pole taps, one tap per cycle.
// Define FMULT_ACCUM_SAT_EN for a saturating accumulator; default wraps modulo 2^16.
module fmult_accum_seq
   import fmult_accum_pkg::*;
#(
   parameter int NZ = 6,
   parameter int NP = 2
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [16*(NZ+NP)-1:0]    a_coef,
   input  logic [11*(NZ+NP)-1:0]    sr,
   output logic                     busy,
   output logic                     done,
   output logic [14:0]              sez,
   output logic [14:0]              se,
   input  logic                     scan_in0,
   input  logic                     scan_en,
   output logic                     scan_out0
);

   localparam int N = NZ + NP;

   state_t           state_r;
   state_t           state_n;
   logic [16*N-1:0]  a_cap_r;
   logic [11*N-1:0]  sr_cap_r;
   logic [4:0]       idx_r;
   logic [15:0]      acc_r;
   logic [15:0]      acc_n;
   logic [15:0]      sezi_r;
   logic [15:0]      tap_a_s;
   logic [10:0]      tap_sr_s;
   logic [15:0]      wan_s;
   logic             busy_r;
   logic             done_r;
   logic [14:0]      sez_r;
   logic [14:0]      se_r;
   logic             unused_scan_s;

   assign unused_scan_s = scan_in0 ^ scan_en;
   assign scan_out0     = 1'b0;

   assign tap_a_s  = a_cap_r[int'(idx_r)*16 +: 16];
   assign tap_sr_s = sr_cap_r[int'(idx_r)*11 +: 11];

   fmult u_fmult (
      .an  (tap_a_s),
      .srn (tap_sr_s),
      .wan (wan_s)
   );

`ifdef FMULT_ACCUM_SAT_EN
   logic [16:0] sum_s;
   assign sum_s = {acc_r[15], acc_r} + {wan_s[15], wan_s};

   // Clamp to the 16-bit signed range when the add overflows.
   always_comb begin
      acc_n = sum_s[15:0];
      if (sum_s[16] != sum_s[15]) begin
         acc_n = sum_s[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         acc_n = sum_s[15:0];
      end
   end
`else
   assign acc_n = acc_r + wan_s;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_n;
   end

   // Next-state decode
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_n = ST_MAC;
            else       state_n = ST_IDLE;
         end
         ST_MAC: begin
            if (idx_r == 5'(N - 1)) state_n = ST_DONE;
            else                    state_n = ST_MAC;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Operand capture, tap accumulation and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         a_cap_r  <= '0;
         sr_cap_r <= '0;
         idx_r    <= 5'd0;
         acc_r    <= 16'd0;
         sezi_r   <= 16'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         sez_r    <= 15'd0;
         se_r     <= 15'd0;
      end else begin
         done_r <= 1'b0;
         busy_r <= (state_n != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               idx_r <= 5'd0;
               if (start) begin
                  a_cap_r  <= a_coef;
                  sr_cap_r <= sr;
                  acc_r    <= 16'd0;
                  sezi_r   <= 16'd0;
               end else begin
                  acc_r <= acc_r;
               end
            end
            ST_MAC: begin
               acc_r <= acc_n;
               idx_r <= idx_r + 5'd1;
               if (idx_r == 5'(NZ - 1)) sezi_r <= acc_n;
               else                     sezi_r <= sezi_r;
            end
            ST_DONE: begin
               // Dropping bit 0 of the 16-bit sum is the arithmetic halving; bit 15 stays the sign.
               done_r <= 1'b1;
               sez_r  <= 15'(sezi_r >> 1);
               se_r   <= 15'(acc_r >> 1);
            end
            default: begin
               idx_r <= 5'd0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sez  = sez_r;
   assign se   = se_r;

endmodule
